// File: rtl/pipeline_sb_param.sv
// pipeline_sb_param: parametrised ID/EX/WB ALU pipeline with a per-register write scoreboard.
// Optional feature macro PIPE_FWD_EN: EX/WB operand forwarding and no stalls; otherwise ID stalls on hazards.
module pipeline_sb_param #(
   parameter  int DW   = 8,
   parameter  int NREG = 4,
   localparam int RW   = $clog2(NREG),
   localparam int IW   = 3 + 3*RW
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [IW-1:0]     inst_i,
   input  logic              inst_valid_i,
   output logic              inst_ready_o,
   input  logic [RW-1:0]     rf_raddr_i,
   output logic [DW-1:0]     rf_rdata_o,
   output logic              wb_valid_o,
   output logic [RW-1:0]     wb_rd_o,
   output logic [DW-1:0]     wb_val_o,
   output logic [2*NREG-1:0] sb_stage_o
);

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_SUB = 3'b010,
      OP_AND = 3'b011,
      OP_LI  = 3'b100
   } op_e;

   logic [DW-1:0]     rf_q [NREG];
   logic [2*NREG-1:0] sb_q;
   logic [2*NREG-1:0] sb_d;

   op_e               exOp_q;
   logic              exWen_q;
   logic [RW-1:0]     exRd_q;
   logic [DW-1:0]     exA_q;
   logic [DW-1:0]     exB_q;

   logic              wbValid_q;
   logic [RW-1:0]     wbRd_q;
   logic [DW-1:0]     wbVal_q;

   op_e               idOp;
   logic [RW-1:0]     idRs1;
   logic [RW-1:0]     idRs2;
   logic [RW-1:0]     idRd;
   logic [2*RW-1:0]   idImm;
   logic              idWen;
   logic              transfer;
   logic [DW-1:0]     opA;
   logic [DW-1:0]     opB;
   logic [DW-1:0]     exResult;

   assign idRs1 = inst_i[3*RW-1 -: RW];
   assign idRs2 = inst_i[2*RW-1 -: RW];
   assign idRd  = inst_i[RW-1:0];
   assign idImm = {idRs1, idRs2};

   // Reserved opcodes 101-111 decode to NOP so they never write or stall.
   always_comb begin
      idOp = OP_NOP;
      case (inst_i[IW-1 -: 3])
         3'b001:  idOp = OP_ADD;
         3'b010:  idOp = OP_SUB;
         3'b011:  idOp = OP_AND;
         3'b100:  idOp = OP_LI;
         default: idOp = OP_NOP;
      endcase
   end

   assign idWen    = (idOp != OP_NOP);
   assign transfer = inst_valid_i && inst_ready_o;

`ifdef PIPE_FWD_EN
   assign inst_ready_o = 1'b1;

   // EX result wins over WB so the youngest pending write to a register is seen.
   always_comb begin
      opA = rf_q[idRs1];
      opB = rf_q[idRs2];
      if (sb_q[{idRs1, 1'b1}]) begin
         opA = exResult;
      end else if (sb_q[{idRs1, 1'b0}]) begin
         opA = wbVal_q;
      end
      if (sb_q[{idRs2, 1'b1}]) begin
         opB = exResult;
      end else if (sb_q[{idRs2, 1'b0}]) begin
         opB = wbVal_q;
      end
   end
`else
   logic idUsesRs;
   logic idHazard;

   assign idUsesRs = (idOp == OP_ADD) || (idOp == OP_SUB) || (idOp == OP_AND);
   assign idHazard = idUsesRs &&
                     ((|sb_q[{idRs1, 1'b0} +: 2]) || (|sb_q[{idRs2, 1'b0} +: 2]));
   assign inst_ready_o = !(inst_valid_i && idHazard);

   always_comb begin
      opA = rf_q[idRs1];
      opB = rf_q[idRs2];
   end
`endif

   always_comb begin
      exResult = '0;
      case (exOp_q)
         OP_ADD:  exResult = exA_q + exB_q;
         OP_SUB:  exResult = exA_q - exB_q;
         OP_AND:  exResult = exA_q & exB_q;
         OP_LI:   exResult = exA_q;
         default: exResult = '0;
      endcase
   end

   // Upper bit of each pair tracks a write entering EX, lower bit follows it into WB.
   always_comb begin
      sb_d = '0;
      for (int r = 0; r < NREG; r++) begin
         sb_d[2*r+1] = transfer && idWen && (idRd == RW'(r));
         sb_d[2*r]   = sb_q[2*r+1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         exOp_q  <= OP_NOP;
         exWen_q <= 1'b0;
         exRd_q  <= '0;
         exA_q   <= '0;
         exB_q   <= '0;
      end else if (transfer) begin
         exOp_q  <= idOp;
         exWen_q <= idWen;
         exRd_q  <= idRd;
         exA_q   <= (idOp == OP_LI) ? DW'(idImm) : opA;
         exB_q   <= (idOp == OP_LI) ? '0 : opB;
      end else begin
         exOp_q  <= OP_NOP;
         exWen_q <= 1'b0;
         exRd_q  <= '0;
         exA_q   <= '0;
         exB_q   <= '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wbValid_q <= 1'b0;
         wbRd_q    <= '0;
         wbVal_q   <= '0;
      end else begin
         wbValid_q <= exWen_q;
         wbRd_q    <= exRd_q;
         wbVal_q   <= exResult;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wbValid_q) begin
         rf_q[wbRd_q] <= wbVal_q;
      end
   end

   assign rf_rdata_o = rf_q[rf_raddr_i];
   assign wb_valid_o = wbValid_q;
   assign wb_rd_o    = wbRd_q;
   assign wb_val_o   = wbVal_q;
   assign sb_stage_o = sb_q;

endmodule
